// File: rtl/fft_input_loader.sv
// fft_input_loader: collects a serial stream of complex samples into two
// ping-pong banks and presents one bank at a time to top_control as flattened
// 32-point real/imag vectors, with a one-cycle fft_start handshake.
module fft_input_loader #(
    parameter int unsigned formatWidth = 9,
    parameter int unsigned points      = 32,
    parameter int unsigned sizeWidth   = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [formatWidth-1:0]        s_real,
    input  logic [formatWidth-1:0]        s_imag,
    input  logic                          s_last,
    input  logic [sizeWidth-1:0]          cfg_size,
    output logic                          fft_start,
    input  logic                          fft_done,
    output logic [sizeWidth-1:0]          fft_size,
    output logic [formatWidth*points-1:0] input_real,
    output logic [formatWidth*points-1:0] input_imag,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          size_err
);

    localparam int unsigned IDX_W = $clog2(points);
    localparam int unsigned VEC_W = formatWidth * points;

    // Bank storage and per-bank frame size
    logic [formatWidth-1:0] bank_re [2][points];
    logic [formatWidth-1:0] bank_im [2][points];
    logic [sizeWidth-1:0]   bank_n  [2];

    // Control state
    logic             fill_sel;
    logic             act_sel;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       bank_full;
    logic             done_q;

    // Next-state values
    logic             fill_sel_d;
    logic             act_sel_d;
    logic [IDX_W-1:0] wr_idx_d;
    logic [1:0]       bank_full_d;
    logic             busy_d;
    logic             s_ready_d;
    logic [sizeWidth-1:0] fft_size_d;
    logic [VEC_W-1:0] re_d;
    logic [VEC_W-1:0] im_d;

    // Decode helpers
    logic                 accept;
    logic                 cfg_legal;
    logic [sizeWidth-1:0] first_n;
    logic [sizeWidth-1:0] cur_n;
    logic                 at_last;
    logic                 closing;
    logic                 done_edge;
    logic                 other;
    logic                 pend_other;
    logic                 launch;
    logic                 launch_sel;
    logic [sizeWidth-1:0] launch_n;
    logic                 launch_closing;
    logic [formatWidth-1:0] ent_re;
    logic [formatWidth-1:0] ent_im;

    // Beat acceptance, size legalisation and frame-position decode
    assign accept     = s_valid && s_ready;
    assign cfg_legal  = (cfg_size >= sizeWidth'(2)) && (cfg_size <= sizeWidth'(points)) &&
                        ((cfg_size & (cfg_size - sizeWidth'(1))) == '0);
    assign first_n    = cfg_legal ? cfg_size : sizeWidth'(points);
    assign cur_n      = (wr_idx == '0) ? first_n : bank_n[fill_sel];
    assign at_last    = (sizeWidth'(wr_idx) == (cur_n - sizeWidth'(1)));
    assign closing    = accept && at_last;
    assign done_edge  = fft_done && !done_q && busy;
    assign other      = ~fill_sel;
    // A full bank that is not the one currently being processed is waiting to launch
    assign pend_other = bank_full[other] && !(busy && (act_sel == other));

    // Next-state computation: fill progress, completion, launch and output vectors
    always_comb begin
        fill_sel_d     = fill_sel;
        act_sel_d      = act_sel;
        wr_idx_d       = wr_idx;
        bank_full_d    = bank_full;
        busy_d         = busy;
        fft_size_d     = fft_size;
        re_d           = input_real;
        im_d           = input_imag;
        launch         = 1'b0;
        launch_sel     = fill_sel;
        launch_n       = '0;
        launch_closing = 1'b0;
        ent_re         = '0;
        ent_im         = '0;

        if (accept) begin
            if (at_last) begin
                wr_idx_d              = '0;
                fill_sel_d            = ~fill_sel;
                bank_full_d[fill_sel] = 1'b1;
            end else begin
                wr_idx_d = wr_idx + IDX_W'(1);
            end
        end

        if (done_edge) begin
            bank_full_d[act_sel] = 1'b0;
            busy_d               = 1'b0;
        end

        // Completion frees the engine in the same cycle, so a waiting bank may launch now
        if (!busy || done_edge) begin
            if (pend_other) begin
                launch     = 1'b1;
                launch_sel = other;
            end else if (closing) begin
                launch     = 1'b1;
                launch_sel = fill_sel;
            end
        end

        if (launch) begin
            launch_closing = closing && (launch_sel == fill_sel);
            launch_n       = launch_closing ? cur_n : bank_n[launch_sel];
            act_sel_d      = launch_sel;
            busy_d         = 1'b1;
            fft_size_d     = launch_n;
            for (int k = 0; k < points; k++) begin
                ent_re = bank_re[launch_sel][k];
                ent_im = bank_im[launch_sel][k];
                // The closing sample is still in flight to the bank; forward it directly
                if (launch_closing && (IDX_W'(k) == wr_idx)) begin
                    ent_re = s_real;
                    ent_im = s_imag;
                end
                if (sizeWidth'(k) >= launch_n) begin
                    ent_re = '0;
                    ent_im = '0;
                end
                re_d[k*formatWidth +: formatWidth] = ent_re;
                im_d[k*formatWidth +: formatWidth] = ent_im;
            end
        end

        s_ready_d = !bank_full_d[fill_sel_d];
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_sel   <= 1'b0;
            act_sel    <= 1'b0;
            wr_idx     <= '0;
            bank_full  <= 2'b00;
            done_q     <= 1'b0;
            busy       <= 1'b0;
            s_ready    <= 1'b0;
            fft_start  <= 1'b0;
            fft_size   <= '0;
            frame_err  <= 1'b0;
            size_err   <= 1'b0;
            input_real <= '0;
            input_imag <= '0;
        end else begin
            fill_sel   <= fill_sel_d;
            act_sel    <= act_sel_d;
            wr_idx     <= wr_idx_d;
            bank_full  <= bank_full_d;
            done_q     <= fft_done;
            busy       <= busy_d;
            s_ready    <= s_ready_d;
            fft_start  <= launch;
            fft_size   <= fft_size_d;
            frame_err  <= accept && (s_last != at_last);
            size_err   <= accept && (wr_idx == '0) && !cfg_legal;
            input_real <= re_d;
            input_imag <= im_d;
        end
    end

    // Sample write into the filling bank; frame size captured on the first beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_n[b] <= '0;
                for (int k = 0; k < points; k++) begin
                    bank_re[b][k] <= '0;
                    bank_im[b][k] <= '0;
                end
            end
        end else if (accept) begin
            bank_re[fill_sel][wr_idx] <= s_real;
            bank_im[fill_sel][wr_idx] <= s_imag;
            if (wr_idx == '0) begin
                bank_n[fill_sel] <= first_n;
            end
        end
    end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Upstream feeder for top_control: collects a serial stream of complex samples (9-bit custom float, 1/4/4) into the flattened 32-point input_real/input_imag vectors.
- Issues the one-cycle fft_start pulse and holds the vectors stable until fft_done.
- Ping-pong banks: the next frame fills while the current FFT runs.

Parameters:
formatWidth, 9, bits per real/imag sample
points, 32, max FFT points / entries per bank
sizeWidth, 11, width of fft_size fields

Ports:
clk  input  1  system clock
rst  input  1  reset: one clock; reset is asynchronous and active-low
s_valid  input  1  sample valid
s_ready  output  1  loader can accept a sample
s_real  input  formatWidth  sample real part
s_imag  input  formatWidth  sample imag part
s_last  input  1  producer's end-of-frame marker
cfg_size  input  sizeWidth  requested FFT size, sampled at the first beat of each frame
fft_start  output  1  one-cycle start pulse to top_control
fft_done  input  1  completion from top_control
fft_size  output  sizeWidth  size of the active frame, to top_control
input_real  output  formatWidth*points  active bank real parts, entry k at bits [k*formatWidth +: formatWidth]
input_imag  output  formatWidth*points  active bank imag parts, same packing
busy  output  1  FFT launched and not yet done
frame_err  output  1  one-cycle pulse: s_last misplaced
size_err  output  1  one-cycle pulse: illegal cfg_size

Behaviour:
- Reset (rst=0, asynchronous) values:
  - fft_start=0, busy=0, frame_err=0, size_err=0, s_ready=0, fft_size=0.
  - Both banks cleared to 0; input_real/input_imag=0.
  - fill_sel=0, act_sel=0, wr_idx=0, bank_full=2'b00.
- s_ready is registered: goes 1 on the first clk after reset release; thereafter s_ready = !(bank_full[fill_sel]).
- Accept: s_valid&&s_ready writes {s_real,s_imag} to bank[fill_sel][wr_idx], then wr_idx++.
- Size capture:
  - On the accept with wr_idx==0, cfg_size is latched as the bank's N.
  - Legal N: 2, 4, 8, 16, 32.
  - Any other value: size_err pulses the next cycle and N=32 is used.
- Frame close:
  - On the accept with wr_idx==N-1: bank_full[fill_sel]<=1, wr_idx<=0, fill_sel toggles.
  - The sample count alone closes the frame; s_last never does.
- frame_err pulses the cycle after an accept where s_last != (wr_idx==N-1). The frame continues regardless.
- Launch:
  - Condition: busy==0 and bank_full[x]==1 for the bank not being filled, or the just-closed bank.
  - Next cycle: act_sel<=x, fft_size<=N[x], fft_start=1 for exactly one cycle, busy<=1.
  - Latency: last-sample accept at cycle T gives fft_start high and new vectors visible at T+1.
- Output mux:
  - input_real/imag = bank[act_sel].
  - Entries with index >= fft_size read 0.
  - The vectors change only in launch cycles.
- Completion:
  - Rising edge of fft_done (registered compare) while busy: bank_full[act_sel]<=0, busy<=0.
  - fft_done while !busy is ignored. A level held high counts once.
- Back-pressure: with both banks full, s_ready=0 until completion frees the active bank.
- Simultaneous events:
  - fft_done edge in the same cycle the other bank closes: completion first, then launch of the new bank one cycle later (fft_start at T+1).
  - Completion and accept in the same cycle are both honoured.
- Reset mid-frame or mid-FFT discards all data. The next frame starts at bank 0, index 0.
- No arithmetic on samples: the data is opaque formatWidth bits.

Test Plan:
- Reset, cfg_size=32, stream 32 beats with s_real=k, s_imag=~k, s_last on beat 31 -> fft_start high exactly 1 cycle after the last accept; input_real entry k = k; fft_size=32; busy=1.
- While busy, stream a second 32-beat frame -> all 32 accepted with s_ready=1, then s_ready=0 and input vectors unchanged. Pulse fft_done -> fft_start one cycle after the fft_done edge; vectors switch to frame 2; s_ready returns to 1.
- cfg_size=8, 8 beats with s_last on beat 7 -> fft_start after beat 7; entries 8..31 read 0; fft_size=8.
- cfg_size=12 -> size_err one pulse; frame closes after 32 beats; fft_size=32.
- cfg_size=32, s_last on beat 5 -> frame_err one pulse on beat 5 and again on beat 31 (no s_last); fft_start only after beat 31.
- Drop rst after 10 beats, then after an FFT launch -> all outputs 0 immediately, no fft_start; a new 32-beat frame then launches normally from index 0. fft_done while idle -> no state change.
